counter_n: RTL and testbench
============================

COUNTER_N -- requirements
Module: counter_n

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 16, counter width in bits.
REQ-003 Parameter MAX, default 5000, terminal count value; the count sequence is 0..MAX inclusive.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 counter_val  output  WIDTH  current count, driven directly from a register.
REQ-007 tc  output  1  terminal-count flag: 1 when counter_val == MAX, else 0 (combinational decode of the count register).

Function
REQ-008 Out of reset, counter_val SHALL increment by exactly 1 on every rising clk edge; there is no enable.
REQ-009 When counter_val == MAX, the next rising edge SHALL load 0 (wrap); counter_val SHALL never exceed MAX.
REQ-010 The period SHALL be MAX+1 clock cycles; tc SHALL be high for exactly 1 cycle per period.
REQ-011 The first edge after reset deassertion SHALL produce counter_val = 1 (0 is held through reset, so no cycle is lost).
REQ-012 MAX = 0 SHALL be legal: counter_val stays 0 and tc stays 1.
REQ-013 MAX = 2^WIDTH-1 SHALL be legal: the natural wrap and the explicit wrap coincide.
REQ-014 Increment arithmetic SHALL be WIDTH bits wide; compare against MAX SHALL be WIDTH bits (MAX truncated cast forbidden, see REQ-018).
REQ-015 All outputs SHALL be free of X after the first reset assertion.

Reset
REQ-016 Asserting rst low at any time, including mid-count or at MAX, SHALL immediately (no clock needed) force counter_val = 0 and tc = (MAX == 0).
REQ-017 While rst is low, the count SHALL hold 0 regardless of clk; counting resumes per REQ-011 on the first rising edge after rst rises.

Structure
REQ-018 The block SHALL check parameters at elaboration: WIDTH >= 1 and MAX <= 2^WIDTH-1, otherwise fatal error.
REQ-019 No shared package is required; WIDTH/MAX are local parameters of the module.
REQ-020 Single module, no sub-modules: one count register, one comparator, and one next-state mux.

Verification
REQ-021 WIDTH=16, MAX=5000: hold rst=0 for 10 cycles -> counter_val=0 and tc=0 throughout.
REQ-022 Release rst and run 5001 edges -> counter_val goes 1,2,...,5000, then 0; tc=1 only while counter_val=5000.
REQ-023 Run 20000 cycles (10 ns clock) -> counter_val always <= 5000; tc pulses every 5001 cycles.
REQ-024 Assert rst mid-cycle while counter_val=1234 -> counter_val=0 before the next clk edge; release -> 1 after the first edge.
REQ-025 WIDTH=4, MAX=15 -> 15 wraps to 0; MAX=0 -> counter_val constant 0, tc constant 1.
REQ-026 WIDTH=4, MAX=16 -> elaboration fails.

Source files
------------

// File: rtl/counter_n_pkg.sv
// counter_n_pkg: elaboration-time parameter legality helper for counter_n
package counter_n_pkg;
  function automatic bit params_ok(input int width, input longint max);
    return width >= 1 && max >= 0 && (width >= 63 || max < (64'sd1 <<< width));
  endfunction
endpackage

// File: rtl/counter_n.sv
// counter_n: free-running 0..MAX wrap counter with terminal-count decode
module counter_n
  import counter_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX = 5000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] counter_val,
  output logic             tc
);
  if (!params_ok(WIDTH, MAX)) begin : g_bad_params
    $fatal(1, "counter_n: illegal WIDTH=%0d MAX=%0d", WIDTH, MAX);
  end
  // MAX has been range-checked, so this cast cannot drop bits
  localparam logic [WIDTH-1:0] max_v = WIDTH'(MAX);
  assign tc = counter_val == max_v;
  always_ff @(posedge clk or negedge rst)
    if (!rst) counter_val <= '0;
    else counter_val <= tc ? '0 : counter_val + WIDTH'(1);
endmodule

// File: tb/tb_counter_n.sv
// tb_counter_n: randomized self-checking bench with a modulo reference model
module tb_counter_n;
  logic clk = 0;
  logic rst = 0;
  logic [15:0] v16;
  logic t16;
  logic [3:0] v15;
  logic t15;
  logic [3:0] v0;
  logic t0;
  int pass_cnt = 0;
  int total = 0;
  int n = 0;
  int last_tc = -1;

  counter_n #(.WIDTH(16), .MAX(5000)) u16 (.clk(clk), .rst(rst), .counter_val(v16), .tc(t16));
  counter_n #(.WIDTH(4), .MAX(15)) u15 (.clk(clk), .rst(rst), .counter_val(v15), .tc(t15));
  counter_n #(.WIDTH(4), .MAX(0)) u0 (.clk(clk), .rst(rst), .counter_val(v0), .tc(t0));

  always #5 clk = ~clk;

  // model state: edges seen since reset release; every expected value is n mod period
  always @(posedge clk or negedge rst)
    if (!rst) n <= 0;
    else n <= n + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    check("val16", v16, n % 5001);
    check("tc16", t16, (n % 5001) == 5000);
    check("val15", v15, n % 16);
    check("tc15", t15, (n % 16) == 15);
    check("val0", v0, 0);
    check("tc0", t0, 1);
    if (!rst) last_tc = -1;
    else if (t16) begin
      if (last_tc >= 0) check("tc_period", n - last_tc, 5001);
      last_tc = n;
    end
  end

  initial begin
    int k;
    repeat (10) @(posedge clk);
    #2 rst = 1;
    repeat (5000) @(posedge clk);
    #1;
    check("pin_max", v16, 5000);
    check("pin_tc_hi", t16, 1);
    @(posedge clk);
    #1;
    check("pin_wrap", v16, 0);
    check("pin_tc_lo", t16, 0);
    check("pin_val15", v15, 9);
    repeat (20000) @(posedge clk);
    k = 0;
    while (v16 != 16'd1234 && k < 6000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_1234", v16, 1234);
    #2 rst = 0;
    #1;
    check("async_val16", v16, 0);
    check("async_tc16", t16, 0);
    check("async_tc0", t0, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #1;
    check("resume", v16, 1);
    k = 0;
    while (v15 != 4'd15 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_15", v15, 15);
    rst = 0;
    #1;
    check("async_at_max15", v15, 0);
    check("async_at_max_tc15", t15, 0);
    @(negedge clk);
    rst = 1;
    repeat (4) begin
      repeat ($urandom_range(1, 6000)) @(posedge clk);
      #($urandom_range(1, 3)) rst = 0;
      #1;
      check("rand_async16", v16, 0);
      check("rand_async15", v15, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(negedge clk);
      rst = 1;
    end
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
